// File: rtl/alu_selftest_ctrl.sv
// Built-in self-test controller for the single-cycle core's ALU: replays a fixed golden
// vector table, compares Result (and flags when ALU_FLAG_CHECK_EN is defined), and reports pass/fail.
module alu_selftest_ctrl #(
  parameter int NUM_VEC       = 12,
  parameter int SETTLE_CYCLES = 1,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [3:0]  fail_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [3:0]  flags;   // {Z, N, C, V}
  } vec_t;

  localparam logic [3:0] LAST_IDX    = 4'(NUM_VEC - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [3:0] NO_FAIL     = 4'hF;

  // Golden table; SUB carry is the carry-out of A + ~B + 1, so 1 means no borrow.
  function automatic vec_t table_entry(input logic [3:0] i);
    case (i)
      4'd0:    return {4'b0000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 4'b0000};
      4'd1:    return {4'b0001, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 4'b0010};
      4'd2:    return {4'b0010, 32'h0000_000F, 32'h0000_00F0, 32'h0000_0000, 4'b1000};
      4'd3:    return {4'b0011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 4'b0000};
      4'd4:    return {4'b0100, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 4'b0000};
      4'd5:    return {4'b0101, 32'h0000_0005, 32'h0000_0010, 32'h0000_0001, 4'b0000};
      4'd6:    return {4'b0110, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 4'b0000};
      4'd7:    return {4'b0111, 32'h0000_0010, 32'h0000_0002, 32'h0000_0004, 4'b0000};
      4'd8:    return {4'b1000, 32'h0000_0005, 32'h0000_0010, 32'h0000_0001, 4'b0000};
      4'd9:    return {4'b1111, 32'h8000_0010, 32'h0000_0002, 32'hE000_0004, 4'b0100};
      4'd10:   return {4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1000};
      4'd11:   return {4'b0001, 32'h0000_0005, 32'h0000_000A, 32'hFFFF_FFFB, 4'b0100};
      default: return '0;
    endcase
  endfunction

  state_t     state;
  logic [3:0] idx;
  logic [3:0] settle_cnt;
  vec_t       cur;
  logic       vec_mismatch;

  assign cur = table_entry(idx);

`ifdef ALU_FLAG_CHECK_EN
  assign vec_mismatch = (alu_result != cur.result) ||
                        ({alu_z, alu_n, alu_c, alu_v} != cur.flags);
`else
  // Flag ports stay on the interface so the core's mux wiring is identical in both builds.
  logic unused_flags;
  assign unused_flags = ^{alu_z, alu_n, alu_c, alu_v, cur.flags};
  assign vec_mismatch = (alu_result != cur.result);
`endif

  // NOTE: every register here is assigned non-blocking so all updates in a cycle see
  // the pre-edge values; blocking assignments would make the order of statements matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_index <= NO_FAIL;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            fail_count <= '0;
            fail_index <= NO_FAIL;
            idx        <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_APPLY;
          end else if (state == S_DONE) begin
            // done/pass rise one cycle after the final check and then hold.
            done <= 1'b1;
            pass <= (fail_count == 5'd0);
          end
        end

        S_APPLY: begin
          alu_a      <= cur.a;
          alu_b      <= cur.b;
          alu_ctrl   <= cur.ctrl;
          settle_cnt <= SETTLE_LOAD;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) state <= S_CHECK;
        end

        S_CHECK: begin
          if (vec_mismatch) begin
            fail_count <= fail_count + 5'd1;
            if (fail_index == NO_FAIL) fail_index <= idx;
          end
          if ((idx == LAST_IDX) || (vec_mismatch && STOP_ON_FAIL)) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= S_APPLY;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_selftest_ctrl.sv
// Self-checking bench: two controller instances (default, and stop-on-fail with longer settle)
// each drive a behavioural ALU with injectable faults; a timeline model predicts every cycle.
module tb_alu_selftest_ctrl;

  localparam int ND = 2;

  localparam logic [3:0]  T_CTRL [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                          4'b0110, 4'b0111, 4'b1000, 4'b1111, 4'b0000, 4'b0001};
  localparam logic [31:0] T_A    [12] = '{32'h5, 32'h5, 32'hF, 32'hF, 32'h1, 32'h5,
                                          32'hFF, 32'h10, 32'h5, 32'h8000_0010, 32'h0, 32'h5};
  localparam logic [31:0] T_B    [12] = '{32'h3, 32'h3, 32'hF0, 32'hF0, 32'h2, 32'h10,
                                          32'hF, 32'h2, 32'h10, 32'h2, 32'h0, 32'hA};
  localparam logic [31:0] T_RES  [12] = '{32'h8, 32'h2, 32'h0, 32'hFF, 32'h4, 32'h1,
                                          32'hF0, 32'h4, 32'h1, 32'hE000_0004, 32'h0, 32'hFFFF_FFFB};
  localparam logic [3:0]  T_FLG  [12] = '{4'h0, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0,
                                          4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h4};

  typedef struct packed {
    logic [31:0] r;
    logic z, n, c, v;
  } alu_out_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        busy, done, pass;
    logic [4:0]  fc;
    logic [3:0]  fi;
  } obs_t;

  function automatic int num_vec(input int d); return (d == 0) ? 12 : 10; endfunction
  function automatic int period(input int d);  return (d == 0) ? 3 : 5;   endfunction
  function automatic bit stop_on(input int d); return d != 0;             endfunction

  // Reference ALU straight from the operation definitions.
  function automatic alu_out_t alu_model(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    alu_out_t o;
    logic [32:0] wide;
    o = '0;
    case (ctrl)
      4'b0000: begin
        wide = {1'b0, a} + {1'b0, b};
        o.r = wide[31:0]; o.c = wide[32];
        o.v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      4'b0001: begin
        wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
        o.r = wide[31:0]; o.c = wide[32];
        o.v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      4'b0010: o.r = a & b;
      4'b0011: o.r = a | b;
      4'b0100: o.r = a << b[4:0];
      4'b0101: o.r = {31'd0, $signed(a) < $signed(b)};
      4'b0110: o.r = a ^ b;
      4'b0111: o.r = a >> b[4:0];
      4'b1000: o.r = {31'd0, a < b};
      4'b1111: o.r = 32'($signed(a) >>> b[4:0]);
      default: o.r = '0;
    endcase
    o.z = (o.r == 32'd0);
    o.n = o.r[31];
    return o;
  endfunction

  function automatic alu_out_t apply_fault(input alu_out_t o, input logic [31:0] f_or,
                                           input logic [31:0] f_xor, input logic [3:0] f_flag);
    alu_out_t q;
    q = o;
    q.r = (o.r | f_or) ^ f_xor;
    {q.z, q.n, q.c, q.v} = {o.z, o.n, o.c, o.v} ^ f_flag;
    return q;
  endfunction

  logic        clk, rst, start;
  logic [31:0] f_or, f_xor;
  logic [3:0]  f_flag;

  logic [31:0] a_o    [ND];
  logic [31:0] b_o    [ND];
  logic [3:0]  ctrl_o [ND];
  logic        busy_o [ND];
  logic        done_o [ND];
  logic        pass_o [ND];
  logic [4:0]  fc_o   [ND];
  logic [3:0]  fi_o   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    alu_out_t ao;
    always_comb ao = apply_fault(alu_model(ctrl_o[g], a_o[g], b_o[g]), f_or, f_xor, f_flag);

    alu_selftest_ctrl #(
      .NUM_VEC      ((g == 0) ? 12 : 10),
      .SETTLE_CYCLES((g == 0) ? 1 : 3),
      .STOP_ON_FAIL ((g == 0) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .alu_a     (a_o[g]),
      .alu_b     (b_o[g]),
      .alu_ctrl  (ctrl_o[g]),
      .alu_result(ao.r),
      .alu_z     (ao.z),
      .alu_n     (ao.n),
      .alu_c     (ao.c),
      .alu_v     (ao.v),
      .busy      (busy_o[g]),
      .done      (done_o[g]),
      .pass      (pass_o[g]),
      .fail_count(fc_o[g]),
      .fail_index(fi_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural timeline model ----------------
  int edge_cnt = 0;
  bit m_have_run [ND];
  int m_k        [ND];
  int m_neff     [ND];
  int m_base     [ND];
  bit m_mis      [ND][12];

  function automatic bit vec_fails(input int i);
    alu_out_t o;
    bit bad;
    o = apply_fault(alu_model(T_CTRL[i], T_A[i], T_B[i]), f_or, f_xor, f_flag);
    bad = (o.r != T_RES[i]);
`ifdef ALU_FLAG_CHECK_EN
    bad = bad || ({o.z, o.n, o.c, o.v} != T_FLG[i]);
`endif
    return bad;
  endfunction

  function automatic bit model_busy_prev(input int d);
    int t;
    t = edge_cnt - 1 - m_k[d];
    return m_have_run[d] && (t >= 0) && (t < m_neff[d] * period(d));
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_have_run[d] = 1'b0;
      end else if (start && !model_busy_prev(d)) begin
        m_base[d]     = m_have_run[d] ? m_neff[d] - 1 : -1;
        m_have_run[d] = 1'b1;
        m_k[d]        = edge_cnt;
        m_neff[d]     = num_vec(d);
        for (int i = 0; i < num_vec(d); i++) m_mis[d][i] = vec_fails(i);
        if (stop_on(d))
          for (int i = num_vec(d) - 1; i >= 0; i--) if (m_mis[d][i]) m_neff[d] = i + 1;
      end
    end
  end

  function automatic obs_t model_obs(input int d);
    obs_t o;
    int t, p, n, v;
    o = '0;
    o.fi = 4'hF;
    if (!m_have_run[d]) return o;
    p = period(d);
    n = m_neff[d];
    t = edge_cnt - m_k[d];
    o.busy = (t < n * p);
    o.done = (t >= n * p + 1);
    if (t == 0) v = m_base[d];
    else begin
      v = (t - 1) / p;
      if (v > n - 1) v = n - 1;
    end
    if (v >= 0) begin
      o.a = T_A[v]; o.b = T_B[v]; o.ctrl = T_CTRL[v];
    end
    for (int i = 0; i < n; i++)
      if (((i + 1) * p <= t) && m_mis[d][i]) begin
        o.fc = o.fc + 5'd1;
        if (o.fi == 4'hF) o.fi = 4'(i);
      end
    o.pass = o.done && (o.fc == 5'd0);
    return o;
  endfunction

  // ---------------- per-cycle compare ----------------
  int   done_edge [ND];
  logic done_prev [ND];

  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      for (int d = 0; d < ND; d++) begin
        obs_t act;
        act = '{a: a_o[d], b: b_o[d], ctrl: ctrl_o[d], busy: busy_o[d], done: done_o[d],
                pass: pass_o[d], fc: fc_o[d], fi: fi_o[d]};
        check($sformatf("dut%0d_cycle%0d", d, edge_cnt), act, model_obs(d));
        if (done_o[d] === 1'b1 && done_prev[d] !== 1'b1) done_edge[d] = edge_cnt;
        done_prev[d] = done_o[d];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!(done_o[0] === 1'b1 && done_o[1] === 1'b1) && c < budget) begin
      @(negedge clk);
      c++;
    end
    #1;
    check("run_completes", {done_o[0], done_o[1]}, 2'b11);
  endtask

  task automatic set_fault(input logic [31:0] o_m, input logic [31:0] x_m, input logic [3:0] fl_m);
    f_or = o_m; f_xor = x_m; f_flag = fl_m;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    alu_out_t pin;
    rst = 1'b1;
    start = 1'b0;
    set_fault('0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reference ALU pinned against hand-computed results.
    pin = alu_model(4'b0001, 32'h5, 32'hA);
    check("model_sub_borrow", {pin.r, pin.z, pin.n, pin.c, pin.v}, {32'hFFFF_FFFB, 4'b0100});
    pin = alu_model(4'b1111, 32'h8000_0010, 32'h2);
    check("model_sra", pin.r, 32'hE000_0004);

    // Golden ALU: full pass, done 37 edges after the start edge (51 for the slow instance).
    repeat (5) @(posedge clk);
    pulse_start();
    wait_done(200);
    check("golden_latency0", done_edge[0] - m_k[0], 37);
    check("golden_latency1", done_edge[1] - m_k[1], 51);
    check("golden_pass0", {pass_o[0], fc_o[0], fi_o[0]}, {1'b1, 5'd0, 4'hF});
    check("golden_pass1", {pass_o[1], fc_o[1], fi_o[1]}, {1'b1, 5'd0, 4'hF});

    // Result bit0 stuck-at-1.
    set_fault(32'h1, '0, '0);
    pulse_start();
    wait_done(200);
    check("stuck0_dut0", {pass_o[0], fc_o[0], fi_o[0]}, {1'b0, 5'd8, 4'h0});
    check("stuck0_dut1", {pass_o[1], fc_o[1], fi_o[1], ctrl_o[1]}, {1'b0, 5'd1, 4'h0, 4'b0000});
    check("stuck0_latency1", done_edge[1] - m_k[1], 6);

    // C flag inverted.
    set_fault('0, '0, 4'b0010);
    pulse_start();
    wait_done(200);
`ifdef ALU_FLAG_CHECK_EN
    check("cflag_dut0", {pass_o[0], fc_o[0], fi_o[0]}, {1'b0, 5'd12, 4'h0});
`else
    check("cflag_dut0", {pass_o[0], fc_o[0], fi_o[0]}, {1'b1, 5'd0, 4'hF});
`endif

    // Reset while the default instance works on vector 5, then a clean rerun.
    set_fault('0, '0, '0);
    pulse_start();
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_mid_run", {busy_o[0], done_o[0], fc_o[0], fi_o[0], a_o[0]}, {1'b0, 1'b0, 5'd0, 4'hF, 32'd0});
    pulse_start();
    wait_done(200);
    check("rerun_after_rst", {pass_o[0], fc_o[0]}, {1'b1, 5'd0});

    // Start while busy is ignored; start straight from DONE reruns cleanly.
    pulse_start();
    repeat (9) @(posedge clk);
    pulse_start();
    wait_done(200);
    check("busy_start_latency", done_edge[0] - m_k[0], 37);
    pulse_start();
    wait_done(200);
    check("done_start_rerun", {pass_o[0], pass_o[1]}, 2'b11);

    // Randomised faults, timing, spurious starts and resets.
    for (int it = 0; it < 30; it++) begin
      int mode, gap;
      case ($urandom_range(0, 4))
        0: set_fault('0, '0, '0);
        1: set_fault(32'h1 << $urandom_range(0, 31), '0, '0);
        2: set_fault('0, 32'h1 << $urandom_range(0, 31), '0);
        3: set_fault('0, '0, 4'(1 << $urandom_range(0, 3)));
        default: set_fault('0, $urandom & $urandom & $urandom, '0);
      endcase
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      pulse_start();
      mode = $urandom_range(0, 2);
      if (mode == 1) begin
        repeat ($urandom_range(1, 40)) @(posedge clk);
        pulse_start();
      end else if (mode == 2) begin
        repeat ($urandom_range(1, 40)) @(posedge clk);
        pulse_rst();
        pulse_start();
      end
      wait_done(300);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
